// File: rtl/wb_conbus_rr_pkg.sv
// Shared types and sizing helpers for the round-robin Wishbone shared-bus interconnect.
package wb_conbus_rr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2
  } bus_state_e;

  // Index width that stays at least one bit wide for single-entry vectors.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/wb_conbus_rr_arbiter.sv
// Round-robin arbiter: picks the first requester strictly after last, wrapping around.
module wb_conbus_rr_arbiter
  import wb_conbus_rr_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld
);

  function automatic int nxt(input int l, input int k);
    return (l + k) % N;
  endfunction

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!gnt_vld && req[nxt(int'(last), k)]) begin
        gnt[nxt(int'(last), k)] = 1'b1;
        gnt_idx                 = IW'(nxt(int'(last), k));
        gnt_vld                 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_conbus_rr.sv
// Shared-bus Wishbone interconnect: round-robin master grant, MSB address decode,
// unmapped-address and per-transfer timeout errors reported back to the granted master.
module wb_conbus_rr
  import wb_conbus_rr_pkg::*;
#(
  parameter int                        N_MASTERS  = 2,
  parameter int                        N_SLAVES   = 8,
  parameter int                        ADR_W      = 32,
  parameter int                        DAT_W      = 32,
  parameter int                        DEC_W      = 3,
  parameter logic [N_SLAVES*DEC_W-1:0] SLAVE_ADDR = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0},
  parameter int                        TIMEOUT    = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_MASTERS*ADR_W-1:0]     m_adr_i,
  input  logic [N_MASTERS*DAT_W-1:0]     m_dat_i,
  input  logic [N_MASTERS*DAT_W/8-1:0]   m_sel_i,
  input  logic [N_MASTERS-1:0]           m_we_i,
  input  logic [N_MASTERS-1:0]           m_cyc_i,
  input  logic [N_MASTERS-1:0]           m_stb_i,
  output logic [N_MASTERS*DAT_W-1:0]     m_dat_o,
  output logic [N_MASTERS-1:0]           m_ack_o,
  output logic [N_MASTERS-1:0]           m_err_o,
  output logic [ADR_W-1:0]               s_adr_o,
  output logic [DAT_W-1:0]               s_dat_o,
  output logic [DAT_W/8-1:0]             s_sel_o,
  output logic                           s_we_o,
  output logic [N_SLAVES-1:0]            s_cyc_o,
  output logic [N_SLAVES-1:0]            s_stb_o,
  input  logic [N_SLAVES*DAT_W-1:0]      s_dat_i,
  input  logic [N_SLAVES-1:0]            s_ack_i,
  input  logic [N_SLAVES-1:0]            s_err_i,
  output logic                           bus_err_o,
  output logic [ADR_W-1:0]               err_adr_o
);

  localparam int MW    = idx_w(N_MASTERS);
  localparam int SW    = idx_w(N_SLAVES);
  localparam int CW    = cnt_w(TIMEOUT);
  localparam int SEL_W = DAT_W / 8;

  bus_state_e           state_q, state_d;
  logic [MW-1:0]        gnt_q, gnt_d, last_q, last_d;
  logic [N_MASTERS-1:0] gnt_oh_q, gnt_oh_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [ADR_W-1:0]     err_adr_q, err_adr_d;

  logic [N_MASTERS-1:0] arb_gnt;
  logic [MW-1:0]        arb_idx;
  logic                 arb_vld;

  wb_conbus_rr_arbiter #(.N(N_MASTERS), .IW(MW)) u_arb (
    .req     (m_cyc_i),
    .last    (last_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  logic [ADR_W-1:0] g_adr;
  logic [DAT_W-1:0] g_dat;
  logic [SEL_W-1:0] g_sel;
  logic             g_we, g_cyc, g_stb;

  assign g_adr = m_adr_i[gnt_q*ADR_W +: ADR_W];
  assign g_dat = m_dat_i[gnt_q*DAT_W +: DAT_W];
  assign g_sel = m_sel_i[gnt_q*SEL_W +: SEL_W];
  assign g_we  = m_we_i[gnt_q];
  assign g_cyc = m_cyc_i[gnt_q];
  assign g_stb = m_stb_i[gnt_q];

  logic [N_SLAVES-1:0] match;
  for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_dec
    assign match[gi] = (g_adr[ADR_W-1 -: DEC_W] == SLAVE_ADDR[gi*DEC_W +: DEC_W]);
  end

  // Overlapping windows resolve to the lowest-numbered slave.
  logic          hit;
  logic [SW-1:0] sidx;
  always_comb begin
    hit  = 1'b0;
    sidx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit  = 1'b1;
        sidx = SW'(i);
      end
    end
  end

  logic busy, err_st, route, sl_ack, sl_err;
  assign busy   = (state_q == ST_BUSY);
  assign err_st = (state_q == ST_ERR);
  assign route  = busy && hit;
  assign sl_ack = route && s_ack_i[sidx];
  assign sl_err = route && s_err_i[sidx] && !s_ack_i[sidx];

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_oh_d  = gnt_oh_q;
    last_d    = last_q;
    cnt_d     = '0;
    err_adr_d = err_adr_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_vld) begin
          gnt_d    = arb_idx;
          gnt_oh_d = arb_gnt;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!g_cyc) begin
          state_d = ST_IDLE;
          last_d  = gnt_q;
        end else if (g_stb && !hit) begin
          state_d   = ST_ERR;
          err_adr_d = g_adr;
        end else if (g_stb && !(sl_ack || s_err_i[sidx])) begin
          // A slave response on the final cycle beats the timeout.
          if (cnt_q == CW'(TIMEOUT - 1)) begin
            state_d   = ST_ERR;
            err_adr_d = g_adr;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_ERR: begin
        if (g_cyc) begin
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
          last_d  = gnt_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      gnt_oh_q  <= '0;
      last_q    <= MW'(N_MASTERS - 1);
      cnt_q     <= '0;
      err_adr_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_oh_q  <= gnt_oh_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      err_adr_q <= err_adr_d;
    end
  end

  logic [DAT_W-1:0] rd_dat;
  always_comb begin
    s_cyc_o = '0;
    s_stb_o = '0;
    rd_dat  = '0;
    if (route) begin
      s_cyc_o[sidx] = g_cyc;
      s_stb_o[sidx] = g_stb;
      rd_dat        = s_dat_i[sidx*DAT_W +: DAT_W];
    end
  end

  assign s_adr_o   = busy ? g_adr : '0;
  assign s_dat_o   = busy ? g_dat : '0;
  assign s_sel_o   = busy ? g_sel : '0;
  assign s_we_o    = busy && g_we;
  assign m_dat_o   = {N_MASTERS{rd_dat}};
  assign m_ack_o   = sl_ack ? gnt_oh_q : '0;
  assign m_err_o   = (sl_err || err_st) ? gnt_oh_q : '0;
  assign bus_err_o = err_st;
  assign err_adr_o = err_adr_q;

endmodule
